phy_reset_sequencer: RTL and testbench
======================================

// Module: phy_reset_sequencer
// PURPOSE
//  Multi-channel PHY power-on/reset sequencer. It replaces the single fixed-counter PHY POR.
//  Each of N_PHY channels has its own hold/settle/ready sequence, with these release sources:
//  per-channel soft request, and a debounced board pushbutton.
//  Sits at the top level between board reset/pushbutton and PHY reset pins.
//  phy_ready gates MAC/system reset release.
// PARAMETERS
//  N_PHY           2          number of PHY channels (>=1)
//  CNT_W           24         width of hold/settle/debounce counters
//  HOLD_CYCLES     1048576    cycles phy_resetn held low (>=1, <2^CNT_W); ~21 ms @50 MHz
//  SETTLE_CYCLES   250000     cycles after release before phy_ready (>=1, <2^CNT_W); 5 ms
//  DEBOUNCE_CYCLES 1000000    consecutive stable cycles to accept pushbutton change (>=1, <2^CNT_W)
// PORTS
//  clk_50_max10  in   1      system clock; all logic on rising edge
//  fpga_reset    in   1      synchronous, active-high reset
//  user_pb_n     in   1      raw pushbutton, active-low, asynchronous; 2-FF synchronised inside
//  rst_req       in   N_PHY  per-channel soft reset request, 1-cycle pulse or level
//  phy_resetn    out  N_PHY  active-low PHY reset, registered
//  phy_ready     out  N_PHY  channel has completed hold+settle, registered
//  all_ready     out  1      &phy_ready (combinational from registers, no extra latency)
//  reset_count   out  8      saturating count of reset events since fpga_reset
// BEHAVIOUR
//  Reset (fpga_reset=1), wins over every other input:
//  - channels in HOLD with counter=0
//  - phy_resetn=0, phy_ready=0, all_ready=0, reset_count=0
//  - pb sync regs=1, debounce counter=0, pb_pressed=0
//  Per-channel FSM states:
//  - HOLD:
//    - phy_resetn=0, phy_ready=0
//    - cnt increments each cycle
//    - when cnt==HOLD_CYCLES-1: -> SETTLE, cnt=0
//    - phy_resetn is low for exactly HOLD_CYCLES cycles
//  - SETTLE:
//    - phy_resetn=1, phy_ready=0
//    - when cnt==SETTLE_CYCLES-1: -> READY, cnt=0
//  - READY: phy_resetn=1, phy_ready=1; holds indefinitely
//  - restart: rst_req[i]=1 in any state (incl. mid-HOLD)
//    - -> HOLD, cnt=0; outputs change on the next edge
//    - level rst_req holds the channel in HOLD at cnt=0
//  - pb_pressed=1 forces all channels to HOLD, cnt=0, every cycle; counting resumes on release
//  Pushbutton:
//  - 2-FF sync -> pb_s
//  - pb_pressed sets when pb_s==0 for DEBOUNCE_CYCLES consecutive cycles
//  - pb_pressed clears when pb_s==1 for DEBOUNCE_CYCLES consecutive cycles
//  - any opposite-level sample resets the debounce counter
//  reset_count:
//  - +1 on a cycle where any channel enters HOLD because of a rising edge of (rst_req[i] | pb_pressed)
//  - max +1 per cycle regardless of how many channels restart
//  - level-held requests count once
//  - saturates at 255; fpga_reset does not count
//  Channels are independent; one channel's restart never disturbs another's state or counter.
//  Counters compare with ==; no wrap possible given the parameter constraints.
// TESTING (N_PHY=2, HOLD=8, SETTLE=4, DEBOUNCE=3; edge 0 = first edge with fpga_reset=0)
//  1 Reset release:
//    - phy_resetn=2'b00 through edge 7, 2'b11 after edge 7
//    - phy_ready=2'b11 and all_ready=1 after edge 11
//    - reset_count=0
//  2 rst_req=2'b10 for one cycle with both channels READY:
//    - phy_resetn[1] low 8 cycles, phy_ready[1] low 12 cycles
//    - channel 0 stays ready; all_ready low 12 cycles
//    - reset_count=1
//  3 rst_req[0] pulse at SETTLE cnt=2: channel 0 restarts full 8-cycle HOLD; no early phy_ready
//  4 Pushbutton glitch vs press:
//    - user_pb_n low 2 cycles -> no change
//    - low 10 cycles -> pb_pressed after sync+3, both channels held in HOLD
//    - after release+debounce -> full 8+4 sequence; reset_count +1
//  5 Simultaneous events:
//    - rst_req=2'b11 in one cycle -> reset_count +1 only
//    - rst_req with fpga_reset=1 -> all in HOLD, reset_count=0
//  6 Saturation: 300 separated rst_req pulses -> reset_count stops at 255; fpga_reset -> 0

Source files
------------

// File: rtl/phy_reset_sequencer.sv
// phy_reset_sequencer: per-channel PHY hold/settle/ready sequencing with soft requests and a debounced pushbutton
module phy_reset_sequencer #(
  parameter int N_PHY           = 2,
  parameter int CNT_W           = 24,
  parameter int HOLD_CYCLES     = 1048576,
  parameter int SETTLE_CYCLES   = 250000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk_50_max10,
  input  logic             fpga_reset,
  input  logic             user_pb_n,
  input  logic [N_PHY-1:0] rst_req,
  output logic [N_PHY-1:0] phy_resetn,
  output logic [N_PHY-1:0] phy_ready,
  output logic             all_ready,
  output logic [7:0]       reset_count
);
  // bit0 drives phy_resetn, bit1 drives phy_ready, so both pins come straight off flops
  localparam logic [1:0] HOLD   = 2'b00;
  localparam logic [1:0] SETTLE = 2'b01;
  localparam logic [1:0] READY  = 2'b11;
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             pb_meta_q, pb_s_q, pb_pressed_q, pb_pressed_d;
  logic [CNT_W-1:0] pb_cnt_q, pb_cnt_d;
  logic [1:0]       state_q [N_PHY];
  logic [1:0]       state_d [N_PHY];
  logic [CNT_W-1:0] cnt_q [N_PHY];
  logic [CNT_W-1:0] cnt_d [N_PHY];
  logic [N_PHY-1:0] req_q, req_d;
  logic [7:0]       count_q, count_d;

  always_comb begin
    pb_cnt_d     = pb_cnt_q + 1'b1;
    pb_pressed_d = pb_pressed_q;
    if (~pb_s_q == pb_pressed_q) pb_cnt_d = '0;
    else if (pb_cnt_q == DB_LAST) begin
      pb_pressed_d = ~pb_s_q;
      pb_cnt_d     = '0;
    end
    req_d      = '0;
    phy_resetn = '0;
    phy_ready  = '0;
    for (int i = 0; i < N_PHY; i++) begin
      req_d[i]      = rst_req[i] | pb_pressed_q;
      phy_resetn[i] = state_q[i][0];
      phy_ready[i]  = state_q[i][1];
      state_d[i]    = state_q[i];
      cnt_d[i]      = cnt_q[i] + 1'b1;
      if (req_d[i]) begin
        state_d[i] = HOLD;
        cnt_d[i]   = '0;
      end else if (state_q[i] == HOLD && cnt_q[i] == HOLD_LAST) begin
        state_d[i] = SETTLE;
        cnt_d[i]   = '0;
      end else if (state_q[i] == SETTLE && cnt_q[i] == SETTLE_LAST) begin
        state_d[i] = READY;
        cnt_d[i]   = '0;
      end else if (state_q[i] == READY) cnt_d[i] = '0;
    end
    // one event per cycle no matter how many channels see a new request
    count_d = (|(req_d & ~req_q) && count_q != 8'hFF) ? count_q + 8'd1 : count_q;
  end

  assign all_ready   = &phy_ready;
  assign reset_count = count_q;

  always_ff @(posedge clk_50_max10) begin
    if (fpga_reset) begin
      pb_meta_q    <= 1'b1;
      pb_s_q       <= 1'b1;
      pb_cnt_q     <= '0;
      pb_pressed_q <= 1'b0;
      req_q        <= '0;
      count_q      <= '0;
      for (int i = 0; i < N_PHY; i++) begin
        state_q[i] <= HOLD;
        cnt_q[i]   <= '0;
      end
    end else begin
      pb_meta_q    <= user_pb_n;
      pb_s_q       <= pb_meta_q;
      pb_cnt_q     <= pb_cnt_d;
      pb_pressed_q <= pb_pressed_d;
      req_q        <= req_d;
      count_q      <= count_d;
      for (int i = 0; i < N_PHY; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end
endmodule

// File: tb/tb_phy_reset_sequencer.sv
// tb_phy_reset_sequencer: directed sequence with an expectation queue for phy_reset_sequencer
module tb_phy_reset_sequencer;
  logic       clk = 1'b0;
  logic       fpga_reset, user_pb_n;
  logic [1:0] rst_req, phy_resetn, phy_ready;
  logic       all_ready;
  logic [7:0] reset_count;
  int checks = 0, failures = 0;

  typedef struct {
    string      tag;
    logic [1:0] rn;
    logic [1:0] rdy;
    logic       all;
    logic [7:0] cnt;
  } exp_t;
  exp_t q[$];

  phy_reset_sequencer #(
    .N_PHY(2), .CNT_W(8), .HOLD_CYCLES(8), .SETTLE_CYCLES(4), .DEBOUNCE_CYCLES(3)
  ) dut (
    .clk_50_max10(clk),
    .fpga_reset(fpga_reset),
    .user_pb_n(user_pb_n),
    .rst_req(rst_req),
    .phy_resetn(phy_resetn),
    .phy_ready(phy_ready),
    .all_ready(all_ready),
    .reset_count(reset_count)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_q();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      checks += 4;
      assert (phy_resetn === e.rn) else begin
        failures++;
        $error("FAIL %s phy_resetn got=%b exp=%b", e.tag, phy_resetn, e.rn);
      end
      assert (phy_ready === e.rdy) else begin
        failures++;
        $error("FAIL %s phy_ready got=%b exp=%b", e.tag, phy_ready, e.rdy);
      end
      assert (all_ready === e.all) else begin
        failures++;
        $error("FAIL %s all_ready got=%b exp=%b", e.tag, all_ready, e.all);
      end
      assert (reset_count === e.cnt) else begin
        failures++;
        $error("FAIL %s reset_count got=%0d exp=%0d", e.tag, reset_count, e.cnt);
      end
    end
  endtask

  // queue the expectation, advance n cycles, then compare against the DUT
  task automatic step(input int n, input string tag, input logic [1:0] rn, input logic [1:0] rdy,
                      input logic [7:0] cnt);
    q.push_back('{tag, rn, rdy, (rdy == 2'b11), cnt});
    cyc(n);
    check_q();
  endtask

  initial begin
    fpga_reset = 1'b1;
    user_pb_n  = 1'b1;
    rst_req    = 2'b00;
    step(3, "reset", 2'b00, 2'b00, 8'd0);
    fpga_reset = 1'b0;
    step(7, "por_hold_e6", 2'b00, 2'b00, 8'd0);
    step(1, "por_release_e7", 2'b11, 2'b00, 8'd0);
    step(3, "por_settle_e10", 2'b11, 2'b00, 8'd0);
    step(1, "por_ready_e11", 2'b11, 2'b11, 8'd0);

    rst_req = 2'b10;
    step(1, "req1_enter", 2'b01, 2'b01, 8'd1);
    rst_req = 2'b00;
    step(7, "req1_hold_end", 2'b01, 2'b01, 8'd1);
    step(1, "req1_release", 2'b11, 2'b01, 8'd1);
    step(3, "req1_settle_end", 2'b11, 2'b01, 8'd1);
    step(1, "req1_ready", 2'b11, 2'b11, 8'd1);

    rst_req = 2'b01;
    step(1, "req0_enter", 2'b10, 2'b10, 8'd2);
    rst_req = 2'b00;
    step(10, "req0_settle_cnt2", 2'b11, 2'b10, 8'd2);
    rst_req = 2'b01;
    step(1, "req0_mid_settle", 2'b10, 2'b10, 8'd3);
    rst_req = 2'b00;
    step(7, "req0_full_hold", 2'b10, 2'b10, 8'd3);
    step(1, "req0_rerelease", 2'b11, 2'b10, 8'd3);
    step(3, "req0_no_early_ready", 2'b11, 2'b10, 8'd3);
    step(1, "req0_ready", 2'b11, 2'b11, 8'd3);

    user_pb_n = 1'b0;
    cyc(2);
    user_pb_n = 1'b1;
    step(10, "pb_glitch", 2'b11, 2'b11, 8'd3);
    user_pb_n = 1'b0;
    step(5, "pb_debouncing", 2'b11, 2'b11, 8'd3);
    step(1, "pb_pressed", 2'b00, 2'b00, 8'd4);
    cyc(4);
    user_pb_n = 1'b1;
    step(5, "pb_held", 2'b00, 2'b00, 8'd4);
    step(7, "pb_hold_end", 2'b00, 2'b00, 8'd4);
    step(1, "pb_release", 2'b11, 2'b00, 8'd4);
    step(3, "pb_settle_end", 2'b11, 2'b00, 8'd4);
    step(1, "pb_ready", 2'b11, 2'b11, 8'd4);

    rst_req = 2'b11;
    step(1, "dual_req", 2'b00, 2'b00, 8'd5);
    rst_req = 2'b00;
    step(12, "dual_ready", 2'b11, 2'b11, 8'd5);
    rst_req = 2'b01;
    step(20, "level_req", 2'b10, 2'b10, 8'd6);
    rst_req = 2'b00;
    step(8, "level_release", 2'b11, 2'b10, 8'd6);
    step(4, "level_ready", 2'b11, 2'b11, 8'd6);
    fpga_reset = 1'b1;
    rst_req    = 2'b11;
    step(1, "reset_wins", 2'b00, 2'b00, 8'd0);
    fpga_reset = 1'b0;
    rst_req    = 2'b00;
    step(12, "rereset_ready", 2'b11, 2'b11, 8'd0);

    for (int i = 0; i < 300; i++) begin
      rst_req = 2'b01;
      cyc(1);
      rst_req = 2'b00;
      cyc(1);
      if (i == 253) step(0, "sat_254", 2'b10, 2'b10, 8'd254);
      if (i == 254) step(0, "sat_255", 2'b10, 2'b10, 8'd255);
    end
    step(0, "sat_hold", 2'b10, 2'b10, 8'd255);
    fpga_reset = 1'b1;
    step(1, "sat_clear", 2'b00, 2'b00, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
